// File: rtl/fc2_serial_mac_pkg.sv
// Shared LeNet-5 datapath definitions: widths, layer sizes,
// FC FSM state encoding and the saturating adder used by FC2/FC3.
package lenet_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam int ACC_WIDTH  = 40;

    localparam int FC1_OUT = 120;
    localparam int FC2_OUT = 84;
    localparam int FC3_OUT = 10;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } fc_state_e;

    localparam data_t DATA_MAX = data_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam data_t DATA_MIN = data_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});

    // One guard bit is enough to detect overflow of a two-operand sum.
    function automatic data_t sat_add(input data_t a, input data_t b);
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            sat_add = s[DATA_WIDTH] ? DATA_MIN : DATA_MAX;
        else
            sat_add = data_t'(s[DATA_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/fc2_serial_mac_if.sv
// FC2 layer bus: enable/done, the three ROM/buffer read ports
// and the FC2 result buffer write port.
interface fc2_serial_mac_if;
    import lenet_pkg::*;

    logic        en;
    logic [6:0]  in_read_addr;
    data_t       in_read_data;
    logic [13:0] weight_addr;
    data_t       weight_data;
    logic [6:0]  bias_addr;
    data_t       bias_data;
    logic        out_write_ena;
    logic [6:0]  out_write_addr;
    data_t       out_write_data;
    logic        done;

    modport master (
        output en, in_read_data, weight_data, bias_data,
        input  in_read_addr, weight_addr, bias_addr,
        input  out_write_ena, out_write_addr, out_write_data, done
    );

    modport slave (
        input  en, in_read_data, weight_data, bias_data,
        output in_read_addr, weight_addr, bias_addr,
        output out_write_ena, out_write_addr, out_write_data, done
    );

endinterface

// File: rtl/fc_mac_unit.sv
// Pipelined signed MAC with product register, clearable accumulator
// and shift/saturate/bias/ReLU output stage; shared by FC2 and FC3.
module fc_mac_unit
    import lenet_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  issue_i,
    input  data_t a_i,
    input  data_t b_i,
    input  data_t bias_i,
    output data_t result_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic                        v1_q, v2_q;
    logic signed [PW-1:0]        a_x, b_x, p_d, p_q;
    logic signed [ACC_WIDTH-1:0] acc_d, acc_q, shifted;
    data_t                       s1, s2;

    assign a_x = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
    assign b_x = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
    assign p_d = a_x * b_x;
    assign acc_d = acc_q + {{(ACC_WIDTH-PW){p_q[PW-1]}}, p_q};

    // v1: ROM data valid this cycle; v2: product register valid.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            p_q   <= '0;
            acc_q <= '0;
        end else begin
            v1_q <= issue_i;
            v2_q <= v1_q;
            if (v1_q)
                p_q <= p_d;
            if (v2_q)
                acc_q <= acc_d;
        end
    end

    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        s1 = DATA_MAX;
        if (&shifted[ACC_WIDTH-1:DATA_WIDTH-1] ||
            ~|shifted[ACC_WIDTH-1:DATA_WIDTH-1])
            s1 = data_t'(shifted[DATA_WIDTH-1:0]);
        else if (shifted[ACC_WIDTH-1])
            s1 = DATA_MIN;
        s2 = sat_add(s1, bias_i);
        result_o = s2[DATA_WIDTH-1] ? '0 : s2;
    end

endmodule

// File: rtl/fc2_serial_mac.sv
// LeNet-5 FC2 layer: 120 -> 84 neurons through one serial MAC,
// sequencing ROM addresses and writing ReLU results to the FC2 buffer.
module fc2_serial_mac
    import lenet_pkg::*;
(
    input logic            clk,
    input logic            rst,
    fc2_serial_mac_if.slave bus
);

    localparam logic [6:0] K_LAST = 7'(FC1_OUT - 1);
    localparam logic [6:0] N_LAST = 7'(FC2_OUT - 1);

    fc_state_e   state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [6:0]  n_q, n_d;
    logic [13:0] w_q, w_d;
    logic        abort, in_mac, wr, clr;
    data_t       mac_out;

    assign abort = !bus.en && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        w_d     = w_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en)
                    state_d = S_MAC;
            end
            S_MAC: begin
                k_d = k_q + 7'd1;
                w_d = w_q + 14'd1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end
            end
            // k doubles as the two-cycle drain counter
            S_DRAIN: begin
                k_d = k_q + 7'd1;
                if (k_q == 7'd1) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                n_d     = n_q + 7'd1;
                state_d = (n_q < N_LAST) ? S_MAC : S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            n_d     = '0;
            w_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            w_q     <= w_d;
        end
    end

    assign in_mac = (state_q == S_MAC);
    assign wr     = (state_q == S_WRITE) && bus.en;
    assign clr    = abort || (state_q == S_WRITE) || (state_q == S_IDLE);

    fc_mac_unit u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .issue_i  (in_mac && bus.en),
        .a_i      (bus.in_read_data),
        .b_i      (bus.weight_data),
        .bias_i   (bus.bias_data),
        .result_o (mac_out)
    );

    assign bus.in_read_addr   = in_mac ? k_q : '0;
    assign bus.weight_addr    = in_mac ? w_q : '0;
    assign bus.bias_addr      = (in_mac || state_q == S_DRAIN ||
                                 state_q == S_WRITE) ? n_q : '0;
    assign bus.out_write_ena  = wr;
    assign bus.out_write_addr = wr ? n_q : '0;
    assign bus.out_write_data = wr ? mac_out : '0;
    assign bus.done           = (state_q == S_DONE) && bus.en;

endmodule
